// File: rtl/fault_pkg.sv
// Shared encodings for the TMR fault monitor: check modes and controller states.
package fault_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_INJ_LO = 2'b01,
        MODE_INJ_HI = 2'b10,
        MODE_BYPASS = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        VOTE  = 2'b10,
        SCRUB = 2'b11
    } state_e;

endpackage

// File: rtl/majority_voter.sv
// Combinational bitwise majority over NUM_CH replicas of a WIDTH-bit word,
// plus a flag per replica that disagrees with the voted word.
module majority_voter #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH*WIDTH-1:0] replicas,
    output logic [WIDTH-1:0]        voted,
    output logic [NUM_CH-1:0]       mismatch
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_CH-1:0] col;
        for (genvar c = 0; c < NUM_CH; c++) begin : g_col
            assign col[c] = replicas[c*WIDTH + b];
        end
        // NUM_CH is odd, so a strict majority always exists
        assign voted[b] = ($countones(col) > (NUM_CH / 2));
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_mis
        assign mismatch[c] = (replicas[c*WIDTH +: WIDTH] != voted);
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Redundant-replica word checker: load, vote, scrub, count faults, raise alarm.
// Optional syndrome log of the last fault is built when FAULT_LOG_EN is defined.
module tmr_fault_monitor
    import fault_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_CH       = 3,
    parameter int CNT_W        = 4,
    parameter int ALARM_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              fault,
    output logic [NUM_CH-1:0] fault_ch,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              alarm,
    output logic [WIDTH-1:0]  fault_syn,
    output logic              busy
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

    state_e                         state_q, state_d;
    mode_e                          mode_q;
    logic [WIDTH-1:0]               din_q, dout_q, maj, vote_word;
    logic [NUM_CH-1:0][WIDTH-1:0]   rep_q, load_val;
    logic [NUM_CH-1:0]              mism;
    logic                           bypass, vote_fault;
    logic [CNT_W-1:0]               cnt_inc;

    majority_voter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) u_voter (
        .replicas (rep_q),
        .voted    (maj),
        .mismatch (mism)
    );

    assign bypass     = (mode_q == MODE_BYPASS);
    assign vote_fault = !bypass && (|mism);
    assign vote_word  = bypass ? rep_q[0] : maj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (din_valid) state_d = LOAD;
            LOAD:    state_d = VOTE;
            VOTE:    state_d = vote_fault ? SCRUB : IDLE;
            SCRUB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        dout_valid = (state_q == VOTE);
        fault      = (state_q == VOTE) && vote_fault;
        fault_ch   = ((state_q == VOTE) && !bypass) ? mism : '0;
        dout       = (state_q == VOTE) ? vote_word : dout_q;
    end

    // Fault injection flips a single bit in exactly one replica
    always_comb begin
        load_val = {NUM_CH{din_q}};
        if (mode_q == MODE_INJ_LO) load_val[0][0] = ~din_q[0];
        if (mode_q == MODE_INJ_HI) load_val[NUM_CH-1][WIDTH-1] = ~din_q[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q  <= '0;
            mode_q <= MODE_NORMAL;
            rep_q  <= '0;
            dout_q <= '0;
        end else begin
            if (state_q == IDLE && din_valid) begin
                din_q  <= din;
                mode_q <= mode_e'(mode);
            end
            if (state_q == LOAD)  rep_q  <= load_val;
            if (state_q == SCRUB) rep_q  <= {NUM_CH{maj}};
            if (state_q == VOTE)  dout_q <= vote_word;
        end
    end

    assign cnt_inc = (fault_cnt == '1) ? fault_cnt : fault_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_cnt <= '0;
            alarm     <= 1'b0;
        end else if (clear) begin
            fault_cnt <= '0;
            alarm     <= 1'b0;
        end else if (fault) begin
            fault_cnt <= cnt_inc;
            if (cnt_inc >= THRESH) alarm <= 1'b1;
        end
    end

`ifdef FAULT_LOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      fault_syn <= '0;
        else if (clear) fault_syn <= '0;
        else if (fault) fault_syn <= rep_q[0] ^ maj;
    end
`else
    assign fault_syn = '0;
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench: transaction-level schedule model plus directed literal checks.
module tb_tmr_fault_monitor;

    logic       clk = 1'b0;
    logic       reset, din_valid, clear;
    logic [7:0] din;
    logic [1:0] mode;
    logic [7:0] dout, fault_syn;
    logic       dout_valid, fault, alarm, busy;
    logic [2:0] fault_ch;
    logic [3:0] fault_cnt;

    tmr_fault_monitor #(.WIDTH(8), .NUM_CH(3), .CNT_W(4), .ALARM_THRESH(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .mode(mode),
        .clear(clear), .dout(dout), .dout_valid(dout_valid), .fault(fault),
        .fault_ch(fault_ch), .fault_cnt(fault_cnt), .alarm(alarm),
        .fault_syn(fault_syn), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle-indexed schedule of accepts and strobes
    int         cyc = 0, free_at = 0, p_cyc = 0, m_cnt = 0;
    bit         p_v = 0, p_f = 0, m_alm = 0, m_s;
    logic [7:0] p_dout = 0, p_syn = 0, hold = 0, m_syn = 0;
    logic [2:0] p_ch = 0;

    task automatic mdl_reset();
        p_v = 0; free_at = 0; m_cnt = 0; m_alm = 0; m_syn = 0; hold = 0;
    endtask

    task automatic mdl_vote(input logic [7:0] d, input logic [1:0] m, output logic [7:0] vd,
                            output logic [2:0] ch, output bit f, output logic [7:0] syn);
        logic [7:0] r [3];
        logic [7:0] mj;
        int ones;
        for (int i = 0; i < 3; i++) r[i] = d;
        if (m == 2'b01) r[0][0] = ~r[0][0];
        if (m == 2'b10) r[2][7] = ~r[2][7];
        for (int b = 0; b < 8; b++) begin
            ones = int'(r[0][b]) + int'(r[1][b]) + int'(r[2][b]);
            mj[b] = (ones >= 2);
        end
        for (int i = 0; i < 3; i++) ch[i] = (m != 2'b11) && (r[i] != mj);
        vd  = (m == 2'b11) ? r[0] : mj;
        f   = |ch;
        syn = r[0] ^ mj;
    endtask

    always @(posedge clk) begin
        if (reset) mdl_reset();
        else begin
            if (clear) begin
                m_cnt = 0; m_alm = 0; m_syn = 0;
            end else if (p_v && p_cyc == cyc && p_f) begin
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                if (m_cnt >= 8) m_alm = 1;
                m_syn = p_syn;
            end
            if (p_v && p_cyc == cyc) begin
                hold = p_dout; p_v = 0;
            end
            if (din_valid && cyc >= free_at) begin
                mdl_vote(din, mode, p_dout, p_ch, p_f, p_syn);
                p_v = 1; p_cyc = cyc + 2;
                free_at = cyc + 3 + (p_f ? 1 : 0);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        m_s = p_v && (p_cyc == cyc);
        chk("dout_valid", dout_valid, m_s);
        chk("dout", dout, m_s ? p_dout : hold);
        chk("fault", fault, m_s && p_f);
        chk("fault_ch", fault_ch, m_s ? p_ch : 3'b000);
        chk("busy", busy, cyc < free_at);
        chk("fault_cnt", fault_cnt, m_cnt);
        chk("alarm", alarm, m_alm);
`ifdef FAULT_LOG_EN
        chk("fault_syn", fault_syn, m_syn);
`else
        chk("fault_syn", fault_syn, 8'h00);
`endif
    end

    // Drives one word; returns at the negedge of the VOTE cycle after literal checks
    task automatic send(input logic [7:0] d, input logic [1:0] m,
                        input logic [7:0] e_dout, input logic [2:0] e_ch);
        @(posedge clk); #1;
        din = d; mode = m; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t_dv", dout_valid, 1'b1);
        chk("t_dout", dout, e_dout);
        chk("t_ch", fault_ch, e_ch);
        chk("t_fault", fault, |e_ch);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 10) begin
            @(negedge clk); n++;
        end
        if (busy) begin
            errs++; checks++;
            $display("FAIL idle_timeout: busy stuck high");
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
    endtask

    int nstrobe;
    logic [7:0] rd;

    initial begin
        reset = 1'b1; din_valid = 1'b0; clear = 1'b0; din = '0; mode = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", fault_cnt, 4'd0);

        // 1: normal word, 2-cycle latency, free again in cycle 3
        send(8'hA5, 2'b00, 8'hA5, 3'b000);
        @(negedge clk);
        chk("t1_busy_c3", busy, 1'b0);

        // 2: inject low, scrub restores replica 0
        send(8'h3C, 2'b01, 8'h3C, 3'b001);
        @(negedge clk);
        chk("t2_cnt", fault_cnt, 4'd1);
`ifdef FAULT_LOG_EN
        chk("t2_syn", fault_syn, 8'h01);
`endif
        @(negedge clk);
        chk("t2_scrub_rep0", dut.rep_q[0], 8'h3C);
        wait_idle();

        // 3: inject high, then a clean word
        send(8'h00, 2'b10, 8'h00, 3'b100);
        wait_idle();
        send(8'h11, 2'b00, 8'h11, 3'b000);
        wait_idle();

        // 4: alarm at the 8th fault, saturation, clear, clear-vs-fault
        pulse_clear();
        chk("t4_clr0", fault_cnt, 4'd0);
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom);
            send(rd, 2'b01, rd, 3'b001);
            @(negedge clk);
            if (i == 6) chk("t4_alarm7", alarm, 1'b0);
            if (i == 7) begin
                chk("t4_alarm8", alarm, 1'b1);
                chk("t4_cnt8", fault_cnt, 4'd8);
            end
            wait_idle();
        end
        chk("t4_sat", fault_cnt, 4'd15);
        chk("t4_sat_alarm", alarm, 1'b1);
        pulse_clear();
        chk("t4_clr_cnt", fault_cnt, 4'd0);
        chk("t4_clr_alarm", alarm, 1'b0);
        send(8'h5A, 2'b10, 8'h5A, 3'b100);
        wait_idle();
        send(8'hC3, 2'b01, 8'hC3, 3'b001);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("t4_clr_coinc", fault_cnt, 4'd0);
        wait_idle();

        // 5: bypass, din_valid held through cycles 0-2 gives one strobe
        @(posedge clk); #1;
        din = 8'hFF; mode = 2'b11; din_valid = 1'b1;
        nstrobe = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dout_valid) nstrobe++;
            if (i == 2) begin
                chk("t5_dout", dout, 8'hFF);
                chk("t5_fault", fault, 1'b0);
                @(posedge clk); #1 din_valid = 1'b0;
            end
        end
        chk("t5_nstrobe", nstrobe, 1);

        // 6: reset during LOAD aborts the word
        send(8'h77, 2'b01, 8'h77, 3'b001);
        wait_idle();
        @(posedge clk); #1;
        din = 8'h5A; mode = 2'b00; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; reset = 1'b1; mdl_reset();
        @(negedge clk);
        chk("t6_dout", dout, 8'h00);
        chk("t6_busy", busy, 1'b0);
        chk("t6_cnt", fault_cnt, 4'd0);
        @(posedge clk); #1 reset = 1'b0;
        nstrobe = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dout_valid) nstrobe++;
        end
        chk("t6_nostrobe", nstrobe, 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            din       = 8'($urandom);
            mode      = 2'($urandom_range(0, 3));
            din_valid = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1; mdl_reset();
            end else reset = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b0; din_valid = 1'b0; clear = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
